// File: rtl/conv_operand_feeder.sv
// Streams (image, kernel) operand pairs for every MxM window of an NxN image,
// one pair per accepted beat, from internal register buffers loaded while idle.
module conv_operand_feeder #(
  parameter int N = 3,
  parameter int M = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic        ready_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic        valid,
  output logic        win_last,
  output logic        frame_last,
  output logic        busy,
  output logic        done
);

  localparam int IMG_SZ = N * N;
  localparam int KER_SZ = M * M;
  localparam int IMG_AW = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1;
  localparam int KER_AW = (KER_SZ > 1) ? $clog2(KER_SZ) : 1;
  localparam logic [7:0] K_LAST = 8'(M - 1);
  localparam logic [7:0] W_LAST = 8'(N - M);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state_q;

  logic [31:0] img_q [IMG_SZ];
  logic [31:0] ker_q [KER_SZ];

  logic [7:0] r_q, c_q, i_q, j_q;
  logic [7:0] r_d, c_d, i_d, j_d;
  logic       win_d, frame_d;

  logic [IMG_AW-1:0] img_rd_addr;
  logic [KER_AW-1:0] ker_rd_addr;

  logic [31:0] a_q, b_q;
  logic        valid_q, win_q, frame_q, busy_q, done_q;
  logic        wr_ok;

  // Buffers are only writable while idle; out-of-range addresses match no element.
  assign wr_ok = wr_en && (state_q == ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < IMG_SZ; gi++) begin : g_img
      always_ff @(posedge clk) begin
        if (rst) begin
          img_q[gi] <= '0;
        end else if (wr_ok && !wr_sel && (wr_addr == 8'(gi))) begin
          img_q[gi] <= wr_data;
        end
      end
    end
    for (gi = 0; gi < KER_SZ; gi++) begin : g_ker
      always_ff @(posedge clk) begin
        if (rst) begin
          ker_q[gi] <= '0;
        end else if (wr_ok && wr_sel && (wr_addr == 8'(gi))) begin
          ker_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Indices of the pair to present next: the first pair when idle, else the successor.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (state_q == ST_IDLE) begin
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else if (j_q == K_LAST) begin
      j_d = '0;
      if (i_q == K_LAST) begin
        i_d = '0;
        if (c_q == W_LAST) begin
          c_d = '0;
          r_d = r_q + 8'd1;
        end else begin
          c_d = c_q + 8'd1;
        end
      end else begin
        i_d = i_q + 8'd1;
      end
    end else begin
      j_d = j_q + 8'd1;
    end
    win_d   = (i_d == K_LAST) && (j_d == K_LAST);
    frame_d = win_d && (r_d == W_LAST) && (c_d == W_LAST);
  end

  assign img_rd_addr = IMG_AW'(32'(r_d + i_d) * N + 32'(c_d + j_d));
  assign ker_rd_addr = KER_AW'(32'(i_d) * M + 32'(j_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      win_q   <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= img_q[img_rd_addr];
            b_q     <= ker_q[ker_rd_addr];
            win_q   <= win_d;
            frame_q <= frame_d;
          end
        end
        ST_RUN: begin
          if (ready_in) begin
            if (frame_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              a_q     <= '0;
              b_q     <= '0;
              win_q   <= 1'b0;
              frame_q <= 1'b0;
            end else begin
              r_q     <= r_d;
              c_q     <= c_d;
              i_q     <= i_d;
              j_q     <= j_d;
              a_q     <= img_q[img_rd_addr];
              b_q     <= ker_q[ker_rd_addr];
              win_q   <= win_d;
              frame_q <= frame_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign valid      = valid_q;
  assign win_last   = win_q;
  assign frame_last = frame_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
